// File: rtl/bp_be_instr_injector_if.sv
// Command and instruction-stream signals of the backend instruction injector.
// The master side issues commands and consumes instruction words; the slave
// side is the injector itself.
interface bp_be_instr_injector_if;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_rs1_i;
  logic [11:0] cmd_csr_i;
  logic [63:0] cmd_imm_i;
  logic [31:0] instr_o;
  logic        instr_v_o;
  logic        instr_ready_i;

  modport master (
    output cmd_v_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_csr_i, cmd_imm_i,
    output instr_ready_i,
    input  cmd_ready_o, instr_o, instr_v_o
  );

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_csr_i, cmd_imm_i,
    input  instr_ready_i,
    output cmd_ready_o, instr_o, instr_v_o
  );
endinterface

// File: rtl/bp_be_instr_injector.sv
// Backend instruction injector: expands abstract commands (LI, CSR read/write,
// FENCE.I, NOP) into RV64 instruction words over a valid/ready stream.
//
// state  | meaning
// -------+------------------------------------------------------------
// e_idle | waiting for a command; cmd_ready_o high unless flushing
// e_emit | presenting word idx of the latched command on instr_o
module bp_be_instr_injector (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  flush_i,
  bp_be_instr_injector_if.slave io,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int instr_width_lp  = 32;
  localparam int cmd_op_width_lp = 3;
  localparam int li_seq_len_lp   = 11;

  localparam logic [cmd_op_width_lp-1:0] op_nop_lp     = 3'd0;
  localparam logic [cmd_op_width_lp-1:0] op_li_lp      = 3'd1;
  localparam logic [cmd_op_width_lp-1:0] op_csr_rd_lp  = 3'd2;
  localparam logic [cmd_op_width_lp-1:0] op_csr_wr_lp  = 3'd3;
  localparam logic [cmd_op_width_lp-1:0] op_fence_i_lp = 3'd4;

  localparam logic [6:0] opc_op_imm_lp   = 7'b0010011;
  localparam logic [6:0] opc_system_lp   = 7'b1110011;
  localparam logic [6:0] opc_misc_mem_lp = 7'b0001111;

  typedef enum logic {e_idle, e_emit} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 idx_q;
  logic [cmd_op_width_lp-1:0] op_q;
  logic [4:0]                 rd_q;
  logic [4:0]                 rs1_q;
  logic [11:0]                csr_q;
  logic [63:0]                imm_q;

  logic                       accept;
  logic                       last;
  logic                       unsupported;
  logic                       done_d;
  logic                       err_d;
  logic [10:0]                chunk;
  logic [instr_width_lp-1:0]  word;

  assign unsupported = (op_q > op_fence_i_lp);
  assign last        = (op_q == op_li_lp) ? (idx_q == 4'(li_seq_len_lp - 1)) : 1'b1;

  // Next-state, handshake outputs and completion pulses; flush beats a final handshake.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    io.cmd_ready_o = 1'b0;
    io.instr_v_o   = 1'b0;
    busy_o         = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    case (state_q)
      e_idle: begin
        io.cmd_ready_o = ~flush_i;
        accept         = io.cmd_v_i & ~flush_i;
        if (accept) state_d = e_emit;
      end
      e_emit: begin
        busy_o       = 1'b1;
        io.instr_v_o = 1'b1;
        if (flush_i) begin
          state_d = e_idle;
        end else if (io.instr_ready_i && last) begin
          state_d = e_idle;
          done_d  = 1'b1;
          err_d   = unsupported;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_idle;
    else            state_q <= state_d;
  end

  // Command latch and word index; idx only advances on a handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      csr_q <= '0;
      imm_q <= '0;
    end else if (state_q == e_idle) begin
      if (accept) begin
        idx_q <= '0;
        op_q  <= io.cmd_op_i;
        rd_q  <= io.cmd_rd_i;
        rs1_q <= io.cmd_rs1_i;
        csr_q <= io.cmd_csr_i;
        imm_q <= io.cmd_imm_i;
      end
    end else begin
      if (flush_i)               idx_q <= '0;
      else if (io.instr_ready_i) idx_q <= last ? 4'd0 : idx_q + 4'd1;
    end
  end

  // One-cycle done/err pulses following the last handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      done_o <= done_d;
      err_o  <= err_d;
    end
  end

  // Instruction word as a pure function of the latched command and idx.
  // LI builds the value 9 bits then 5 x 11 bits, so every immediate field is
  // non-negative and no sign-carry correction is needed.
  always_comb begin
    word  = '0;
    chunk = '0;
    case (idx_q)
      4'd2:    chunk = imm_q[54:44];
      4'd4:    chunk = imm_q[43:33];
      4'd6:    chunk = imm_q[32:22];
      4'd8:    chunk = imm_q[21:11];
      4'd10:   chunk = imm_q[10:0];
      default: chunk = '0;
    endcase
    if (state_q == e_emit) begin
      case (op_q)
        op_nop_lp: word = {12'd0, 5'd0, 3'b000, 5'd0, opc_op_imm_lp};
        op_li_lp: begin
          if (idx_q == 4'd0)
            word = {3'b000, imm_q[63:55], 5'd0, 3'b000, rd_q, opc_op_imm_lp};
          else if (idx_q[0])
            word = {6'b000000, 6'd11, rd_q, 3'b001, rd_q, opc_op_imm_lp};
          else
            word = {1'b0, chunk, rd_q, 3'b110, rd_q, opc_op_imm_lp};
        end
        op_csr_rd_lp:  word = {csr_q, 5'd0, 3'b010, rd_q, opc_system_lp};
        op_csr_wr_lp:  word = {csr_q, rs1_q, 3'b001, 5'd0, opc_system_lp};
        op_fence_i_lp: word = {12'd0, 5'd0, 3'b001, 5'd0, opc_misc_mem_lp};
        default:       word = {12'd0, 5'd0, 3'b000, 5'd0, opc_op_imm_lp};
      endcase
    end
  end

  assign io.instr_o = word;

endmodule

// File: doc/bp_be_instr_injector.md
# bp_be_instr_injector

Sequencer that turns abstract backend commands (64-bit load-immediate, CSR read, CSR write, FENCE.I, NOP) into a stream of legal RV64 instruction words. It is the encoding counterpart of the backend instruction decoder. It sits beside the FE queue and feeds its words into the decoder's instruction input through a valid/ready handshake, serving debug abstract commands and trap-handler stubs.

## Interface
Parameters:
- instr_width_lp, 32 (localparam): width of an emitted instruction word
- cmd_op_width_lp, 3 (localparam): command opcode width
- li_seq_len_lp, 11 (localparam): number of instructions in a load-immediate sequence

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_n_i  input  1  reset, asynchronous, active-low
- cmd_v_i  input  1  command valid
- cmd_ready_o  output  1  command accept; high only in IDLE with flush_i low
- cmd_op_i  input  3  command: 0 NOP, 1 LI, 2 CSR_RD, 3 CSR_WR, 4 FENCE_I, 5-7 unsupported
- cmd_rd_i  input  5  destination GPR (LI, CSR_RD)
- cmd_rs1_i  input  5  source GPR (CSR_WR)
- cmd_csr_i  input  12  CSR address
- cmd_imm_i  input  64  immediate (LI)
- flush_i  input  1  abort the current sequence
- instr_o  output  32  instruction word
- instr_v_o  output  1  instr_o valid
- instr_ready_i  input  1  consumer accepts instr_o
- busy_o  output  1  high in the EMIT state
- done_o  output  1  one-cycle pulse after the last instruction of a sequence handshakes
- err_o  output  1  one-cycle pulse coincident with done_o when the command was unsupported

## Operation
- State machine with two states, IDLE and EMIT.
  - IDLE to EMIT when cmd_v_i and cmd_ready_o are both high. The command fields are latched and the index counter idx is cleared.
  - EMIT to IDLE on the handshake of the last instruction, or on flush_i.
- Sequences (instruction words in RV64 base encoding):
  - NOP: ADDI x0,x0,0 (0x00000013). Length 1.
  - CSR_RD: CSRRS rd,csr,x0. Length 1.
  - CSR_WR: CSRRW x0,csr,rs1. Length 1.
  - FENCE_I: 0x0000100F. Length 1.
  - LI: length 11, no carry correction needed because every immediate is non-negative.
    - idx 0: ADDI rd,x0,imm[63:55] (9-bit value, zero-extended to 12 bits).
    - Odd idx k (1,3,5,7,9): SLLI rd,rd,11 (shamt field 6'd11).
    - Even idx k (2..10): ORI rd,rd,imm[54-11*(k/2-1) -: 11], zero-extended.
  - Unsupported op: emits a NOP (length 1), then err_o pulses with done_o.
- cmd_rd_i==0 for LI or CSR_RD is legal. The words are emitted unmodified.
- idx increments only on the instr_v_o and instr_ready_i handshake. instr_o is a pure function of the latched command and idx, so it stays stable while stalled.
- flush_i in EMIT: next cycle state is IDLE, instr_v_o is 0 and idx is 0, with no done_o and no err_o. flush_i in IDLE: cmd_ready_o is forced low, so no command is accepted that cycle.
- flush_i has priority over a same-cycle final handshake. The handshake is ignored and done_o does not pulse.

## Timing
- Reset values: state IDLE, idx 0, instr_v_o 0, instr_o 0, busy_o 0, done_o 0, err_o 0. cmd_ready_o is 1 once reset_n_i deasserts. Asserting reset_n_i mid-sequence clears everything immediately, asynchronously.
- Command accepted in cycle N: instr_v_o=1 and busy_o=1 from cycle N+1.
- With instr_ready_i held high, the words occupy consecutive cycles. LI takes cycles N+1..N+11; done_o is high in N+12 with state back in IDLE.
- done_o and cmd_ready_o are both high in the same cycle, so a new command can be accepted then. Its first word appears the following cycle, giving a one-cycle bubble between sequences.
- instr_v_o never drops without a handshake or flush_i. instr_o must not change while instr_v_o=1 and instr_ready_i=0.
- busy_o equals (state==EMIT). instr_v_o equals busy_o.

## Test plan
- Reset then LI x5 with imm 0x0123456789ABCDEF, ready held high:
  - 11 words on consecutive cycles.
  - Word 0 = 0x00200293, word 1 = 0x00B29293, word 10 = 0x5EF2E293.
  - done_o pulses in cycle N+12.
  - A reference-model ISS executing the words leaves x5 = 0x0123456789ABCDEF.
- CSR_RD rd=10 csr=0xF14 -> single word 0xF1402573. CSR_WR rs1=6 csr=0x340 -> single word 0x34031073. done_o pulses once per command, err_o stays 0.
- LI with instr_ready_i toggling randomly (50%) -> same 11 words in order, each held stable while stalled, no duplicate and no dropped word.
- flush_i asserted at idx 4 of LI -> next cycle instr_v_o=0 and busy_o=0, no done_o. A following FENCE_I command emits 0x0000100F.
- cmd_op_i=6 -> one word 0x00000013, then done_o=1 and err_o=1 in the same cycle.
- reset_n_i pulsed low mid-LI at idx 7 -> outputs return to reset values asynchronously, within the same cycle. After release, cmd_ready_o=1 and the next command starts at idx 0.
